// File: rtl/press_decoder.sv
// press_decoder: classifies debounced button gestures as short, long or
// double presses. Emits one single-cycle pulse per gesture and a registered
// "held" level. btnIn must already be clean and synchronous to clk.
module press_decoder #(
  parameter logic [22:0] LONG_CYCLES = 23'd20,
  parameter logic [22:0] GAP_CYCLES  = 23'd15
) (
  input  logic clk,
  input  logic rst,
  input  logic btnIn,
  output logic shortPulse,
  output logic longPulse,
  output logic doublePulse,
  output logic held
);

  // Gesture states. Values 5..7 are unused and fall back to IDLE.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESS1    = 3'd1;
  localparam logic [2:0] S_LONG_HELD = 3'd2;
  localparam logic [2:0] S_WAIT_GAP  = 3'd3;
  localparam logic [2:0] S_PRESS2    = 3'd4;

  // Terminal counts: the counter starts at 0 on state entry, so the
  // threshold edge is the one that sees count == N-1.
  localparam logic [22:0] LONG_LAST = LONG_CYCLES - 23'd1;
  localparam logic [22:0] GAP_LAST  = GAP_CYCLES - 23'd1;

  logic [2:0]  r_state;
  logic [22:0] r_count;
  logic        r_btn_prev;
  logic        r_short;
  logic        r_long;
  logic        r_double;
  logic        r_held;

  logic        w_rise;
  logic        w_fall;
  logic [2:0]  w_state_nxt;
  logic [22:0] w_count_nxt;
  logic        w_short_nxt;
  logic        w_long_nxt;
  logic        w_double_nxt;
  logic        w_held_nxt;

  // Edges are taken against the previous sampled level; the previous level
  // resets to 0, so a button held through reset is seen as a fresh press.
  assign w_rise = btnIn & ~r_btn_prev;
  assign w_fall = ~btnIn & r_btn_prev;

  // Next-state decode: pulses default low, held and count default to hold.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_double_nxt = 1'b0;
    w_held_nxt   = r_held;
    case (r_state)
      S_IDLE: begin
        w_held_nxt = 1'b0;
        if (w_rise) begin
          w_state_nxt = S_PRESS1;
          w_count_nxt = 23'd0;
          w_held_nxt  = 1'b1;
        end
      end
      S_PRESS1: begin
        w_held_nxt = 1'b1;
        if (w_fall) begin
          w_state_nxt = S_WAIT_GAP;
          w_count_nxt = 23'd0;
          w_held_nxt  = 1'b0;
        end else if (r_count == LONG_LAST) begin
          w_state_nxt = S_LONG_HELD;
          w_long_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + 23'd1;
        end
      end
      S_LONG_HELD: begin
        // A long press is already reported; release just returns to idle.
        w_held_nxt = 1'b1;
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = 23'd0;
          w_held_nxt  = 1'b0;
        end
      end
      S_WAIT_GAP: begin
        w_held_nxt = 1'b0;
        // A second press on the timeout edge still wins: double press.
        if (w_rise) begin
          w_state_nxt = S_PRESS2;
          w_count_nxt = 23'd0;
          w_held_nxt  = 1'b1;
        end else if (r_count == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = 23'd0;
          w_short_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + 23'd1;
        end
      end
      S_PRESS2: begin
        // No long detection here: any second press ends as a double.
        w_held_nxt = 1'b1;
        if (w_fall) begin
          w_state_nxt  = S_IDLE;
          w_count_nxt  = 23'd0;
          w_double_nxt = 1'b1;
          w_held_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = 23'd0;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= 23'd0;
      r_btn_prev <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_double   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_btn_prev <= btnIn;
      r_short    <= w_short_nxt;
      r_long     <= w_long_nxt;
      r_double   <= w_double_nxt;
      r_held     <= w_held_nxt;
    end
  end

  assign shortPulse  = r_short;
  assign longPulse   = r_long;
  assign doublePulse = r_double;
  assign held        = r_held;

endmodule

// File: tb/tb_press_decoder.sv
// tb_press_decoder: directed gesture scenarios plus randomized button
// traffic, each cycle compared against a timestamp-based gesture model.
module tb_press_decoder;

  localparam int LONG = 20;
  localparam int GAP  = 15;

  localparam int P_IDLE   = 0;
  localparam int P_FIRST  = 1;
  localparam int P_LONG   = 2;
  localparam int P_GAP    = 3;
  localparam int P_SECOND = 4;

  logic clk = 1'b0;
  logic rst;
  logic btnIn;
  logic shortPulse;
  logic longPulse;
  logic doublePulse;
  logic held;

  press_decoder #(
    .LONG_CYCLES(23'd20),
    .GAP_CYCLES (23'd15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btnIn      (btnIn),
    .shortPulse (shortPulse),
    .longPulse  (longPulse),
    .doublePulse(doublePulse),
    .held       (held)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: gesture phase, edge number when the phase began, edge counter.
  int   m_ph = P_IDLE;
  int   m_t0 = 0;
  int   m_n  = 0;
  logic m_prev = 1'b0;
  logic [3:0] m_exp = 4'b0;  // {short, long, double, held}

  // Apply one clock of stimulus and advance the model by one edge.
  task automatic tick(input logic b, input logic r);
    logic rise, fall;
    btnIn = b;
    rst   = r;
    @(posedge clk);
    m_n++;
    m_exp = 4'b0;
    if (r) begin
      m_ph   = P_IDLE;
      m_prev = 1'b0;
    end else begin
      rise   = b & ~m_prev;
      fall   = ~b & m_prev;
      m_prev = b;
      case (m_ph)
        P_IDLE:   if (rise) begin m_ph = P_FIRST; m_t0 = m_n; end
        P_FIRST: begin
          if (fall) begin m_ph = P_GAP; m_t0 = m_n; end
          else if (m_n - m_t0 == LONG) begin m_ph = P_LONG; m_exp[2] = 1'b1; end
        end
        P_LONG:   if (fall) m_ph = P_IDLE;
        P_GAP: begin
          if (rise) begin m_ph = P_SECOND; m_t0 = m_n; end
          else if (m_n - m_t0 == GAP) begin m_ph = P_IDLE; m_exp[3] = 1'b1; end
        end
        P_SECOND: if (fall) begin m_ph = P_IDLE; m_exp[1] = 1'b1; end
        default:  m_ph = P_IDLE;
      endcase
    end
    m_exp[0] = (m_ph == P_FIRST) || (m_ph == P_LONG) || (m_ph == P_SECOND);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      if ({shortPulse, longPulse, doublePulse, held} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d got=%b want=0000", i, {shortPulse, longPulse, doublePulse, held});
      end
      n_vec++;
    end
    tick(1'b1, 1'b0);
    if (held !== 1'b1) begin
      n_err++;
      $display("FAIL reset_held_after_release got=%b want=1", held);
    end
    n_vec++;
    for (int i = 0; i < GAP + 5; i++) begin
      tick(1'b0, 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL reset_drain edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
    end
  endtask

  task automatic test_short();
    int sc = 0, lc = 0, dc = 0, hc = 0, short_at = -1;
    for (int i = 0; i < 5 + GAP + 5; i++) begin
      tick((i < 5) ? 1'b1 : 1'b0, 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL short_seq edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
      sc += int'(shortPulse); lc += int'(longPulse); dc += int'(doublePulse); hc += int'(held);
      if (shortPulse) short_at = i - 5;
    end
    if (sc != 1 || lc != 0 || dc != 0 || hc != 5 || short_at != GAP) begin
      n_err++;
      $display("FAIL short_summary got s=%0d l=%0d d=%0d held=%0d at=%0d want s=1 l=0 d=0 held=5 at=%0d",
               sc, lc, dc, hc, short_at, GAP);
    end
    n_vec++;
  endtask

  task automatic test_long();
    int sc = 0, lc = 0, long_at = -1;
    for (int i = 0; i < 30 + GAP + 5; i++) begin
      tick((i < 30) ? 1'b1 : 1'b0, 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL long_seq edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
      sc += int'(shortPulse); lc += int'(longPulse);
      if (longPulse) long_at = i;
      if (i == 29 && held !== 1'b1) begin
        n_err++;
        $display("FAIL long_held_level got=%b want=1", held);
      end
    end
    if (sc != 0 || lc != 1 || long_at != LONG) begin
      n_err++;
      $display("FAIL long_summary got s=%0d l=%0d at=%0d want s=0 l=1 at=%0d", sc, lc, long_at, LONG);
    end
    n_vec++;
  endtask

  task automatic test_double();
    int sc = 0, dc = 0, double_at = -1;
    // press 4, low 6, press 3, then low
    for (int i = 0; i < 13 + GAP + 5; i++) begin
      tick((i < 4 || (i >= 10 && i < 13)) ? 1'b1 : 1'b0, 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL double_seq edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
      sc += int'(shortPulse); dc += int'(doublePulse);
      if (doublePulse) double_at = i;
    end
    if (sc != 0 || dc != 1 || double_at != 13) begin
      n_err++;
      $display("FAIL double_summary got s=%0d d=%0d at=%0d want s=0 d=1 at=13", sc, dc, double_at);
    end
    n_vec++;
  endtask

  task automatic test_collision();
    int sc = 0, dc = 0;
    // press 4, low for GAP edges, rise on the timeout edge, press 3, release
    for (int i = 0; i < 4 + GAP + 3 + GAP + 5; i++) begin
      tick((i < 4 || (i >= 4 + GAP && i < 4 + GAP + 3)) ? 1'b1 : 1'b0, 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL collision_seq edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
      sc += int'(shortPulse); dc += int'(doublePulse);
    end
    if (sc != 0 || dc != 1) begin
      n_err++;
      $display("FAIL collision_summary got s=%0d d=%0d want s=0 d=1", sc, dc);
    end
    n_vec++;
  endtask

  task automatic test_mid_reset();
    int sc = 0;
    // press 4, then 11 low edges (gap counter reaches 10), reset one edge
    for (int i = 0; i < 4 + 11 + 1 + GAP + 5; i++) begin
      tick((i < 4) ? 1'b1 : 1'b0, (i == 15) ? 1'b1 : 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL midreset_seq edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
      sc += int'(shortPulse);
    end
    if (sc != 0) begin
      n_err++;
      $display("FAIL midreset_no_short got s=%0d want s=0", sc);
    end
    n_vec++;
    sc = 0;
    for (int i = 0; i < 3 + GAP + 5; i++) begin
      tick((i < 3) ? 1'b1 : 1'b0, 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL midreset_after edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
      sc += int'(shortPulse);
    end
    if (sc != 1) begin
      n_err++;
      $display("FAIL midreset_next_short got s=%0d want s=1", sc);
    end
    n_vec++;
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int len;
    for (int s = 0; s < 60; s++) begin
      lvl = ~lvl;
      len = int'($urandom_range(1, 35));
      for (int i = 0; i < len; i++) begin
        tick(lvl, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
          n_err++;
          $display("FAIL random_seq edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
        end
        n_vec++;
      end
    end
    for (int i = 0; i < GAP + 5; i++) begin
      tick(1'b0, 1'b0);
      if ({shortPulse, longPulse, doublePulse, held} !== m_exp) begin
        n_err++;
        $display("FAIL random_drain edge%0d got=%b want=%b", m_n, {shortPulse, longPulse, doublePulse, held}, m_exp);
      end
      n_vec++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    btnIn = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_collision();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound in case the stimulus loop ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
